amrx_envelope: RTL

//  AM envelope receiver: inverse of the AM transmit chain. Accepts baseband I/Q samples
//  on a clock-enable strobe, forms the envelope magnitude and removes the carrier DC term.

---
 rtl/amrx_envelope.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/amrx_envelope.sv
// AM envelope receiver: |I/Q| magnitude, optional carrier DC blocker, Q8.8 gain with saturation, 1-bit sigma-delta out.
// Define AMRX_DCBLOCK_EN to build the DC blocker; without it hp = mag and register 2 reads 0.
module amrx_envelope #(
  parameter int IW   = 16,
  parameter int OW   = 16,
  parameter int LGDC = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic signed [IW-1:0] i_i,
  input  logic signed [IW-1:0] i_q,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [1:0]           i_wb_addr,
  input  logic [31:0]          i_wb_data,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [31:0]          o_wb_data,
  output logic                 o_audio_ce,
  output logic signed [OW-1:0] o_audio,
  output logic                 o_sd
);
  localparam int PW = IW + 18;
  localparam logic signed [PW-1:0] YMAX = PW'(2**(OW-1) - 1);
  localparam logic signed [PW-1:0] YMIN = PW'(-(2**(OW-1)));

  logic                 wb_wr;
  logic [15:0]          gain;
  logic                 clr_pulse;
  logic [31:0]          sat_cnt;
  logic [31:0]          rd_data;
  logic [31:0]          dc_rd;
  logic                 v1, v2, v3, v4;
  logic [IW-1:0]        abs_i, abs_q, mx, mn;
  logic [IW:0]          mag, dc;
  logic signed [IW+1:0] hp, hp_next;
  logic signed [PW-1:0] prod, y;
  logic                 sat_hi, sat_lo;
  logic [OW:0]          sd_acc;
  logic                 unused_bits;

  function automatic logic [IW-1:0] abs_val(input logic [IW-1:0] x);
    return x[IW-1] ? (~x + 1'b1) : x;
  endfunction

  assign wb_wr       = i_wb_cyc & i_wb_stb & i_wb_we;
  assign o_wb_stall  = 1'b0;
  assign unused_bits = ^{i_wb_data[30:16], clr_pulse};

  // Each stage captures only when its valid bit is set, so results hold between strobes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      v4    <= 1'b0;
      abs_i <= '0;
      abs_q <= '0;
      mx    <= '0;
      mn    <= '0;
      mag   <= '0;
      hp    <= '0;
    end else begin
      v1 <= i_ce;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
      if (i_ce) begin
        abs_i <= abs_val(i_i);
        abs_q <= abs_val(i_q);
      end
      if (v1) begin
        mx <= (abs_i > abs_q) ? abs_i : abs_q;
        mn <= (abs_i > abs_q) ? abs_q : abs_i;
      end
      if (v2)
        mag <= (IW+1)'(mx) - (IW+1)'(mx >> 3) + (IW+1)'(mn >> 1);
      if (v3)
        hp <= hp_next;
    end
  end

`ifdef AMRX_DCBLOCK_EN
  logic [IW+LGDC:0] dc_acc;
  logic [IW:0]      dc_raw;

  assign dc_raw = dc_acc[IW+LGDC:LGDC];
  // A clear landing on the same clock as a sample makes that sample see dc = 0.
  assign dc     = clr_pulse ? '0 : dc_raw;
  assign dc_rd  = {{(31-IW){dc_raw[IW]}}, dc_raw};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      dc_acc <= '0;
    else if (clr_pulse)
      dc_acc <= '0;
    else if (v3)
      dc_acc <= dc_acc + (IW+LGDC+1)'(mag) - (IW+LGDC+1)'(dc);
  end
`else
  localparam int lgdc_unused = LGDC;
  assign dc    = '0;
  assign dc_rd = '0;
`endif

  assign hp_next = $signed({1'b0, mag}) - $signed({1'b0, dc});
  assign prod    = hp * $signed(gain);
  assign y       = prod >>> 8;
  assign sat_hi  = y > YMAX;
  assign sat_lo  = y < YMIN;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_audio    <= '0;
      o_audio_ce <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      o_audio_ce <= v4;
      if (v4)
        o_audio <= sat_hi ? {1'b0, {(OW-1){1'b1}}} :
                   sat_lo ? {1'b1, {(OW-1){1'b0}}} : y[OW-1:0];
      if (wb_wr && i_wb_addr == 2'd3)
        sat_cnt <= '0;
      else if (v4 && (sat_hi || sat_lo) && sat_cnt != 32'hFFFF_FFFF)
        sat_cnt <= sat_cnt + 32'd1;
    end
  end

  // Offset-binary first-order modulator: zero audio gives a 50% duty alternating bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      sd_acc <= '0;
    else
      sd_acc <= {1'b0, sd_acc[OW-1:0]} + {1'b0, ~o_audio[OW-1], o_audio[OW-2:0]};
  end
  assign o_sd = sd_acc[OW];

  always_comb begin
    rd_data = '0;
    case (i_wb_addr)
      2'd0: rd_data = {16'h0, gain};
      2'd1: rd_data = {{(31-IW){1'b0}}, mag};
      2'd2: rd_data = dc_rd;
      2'd3: rd_data = sat_cnt;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      gain      <= 16'h0100;
      clr_pulse <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= i_wb_stb;
      clr_pulse <= wb_wr && (i_wb_addr == 2'd0) && i_wb_data[31];
      if (wb_wr && i_wb_addr == 2'd0)
        gain <= i_wb_data[15:0];
      if (i_wb_stb)
        o_wb_data <= rd_data;
    end
  end
endmodule
